// File: rtl/gen1_2_rx_packet_filter.sv
// Gen1/2 receive packet filter: follows TLP/DLLP framing across beats and emits registered
// per-byte payload, end, nullify and error masks plus saturating statistics counters.
module gen1_2_rx_packet_filter #(
  parameter int unsigned N_BYTES  = 64,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned DLLP_LEN = 6
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [8*N_BYTES-1:0] data_in,
  input  logic [N_BYTES-1:0]   valid_in,
  input  logic [N_BYTES-1:0]   tlpstart,
  input  logic [N_BYTES-1:0]   tlpend,
  input  logic [N_BYTES-1:0]   tlpedb,
  input  logic [N_BYTES-1:0]   dlpstart,
  input  logic [N_BYTES-1:0]   dlpend,
  input  logic                 clr_cnt,
  output logic [8*N_BYTES-1:0] data_out,
  output logic [N_BYTES-1:0]   tlp_be,
  output logic [N_BYTES-1:0]   tlp_end,
  output logic [N_BYTES-1:0]   tlp_nullify,
  output logic [N_BYTES-1:0]   dllp_be,
  output logic [N_BYTES-1:0]   dllp_end,
  output logic [N_BYTES-1:0]   frame_err,
  output logic                 err_pulse,
  output logic [CNT_W-1:0]     tlp_cnt,
  output logic [CNT_W-1:0]     dllp_cnt,
  output logic [CNT_W-1:0]     err_cnt
);

  typedef enum logic [1:0] {StIdle, StTlp, StDllp} mode_e;

  localparam logic [2:0] DllpLen = 3'(DLLP_LEN);

  mode_e      mode_q, mode_d, cur_mode;
  logic [2:0] dcnt_q, dcnt_d, cur_cnt;
  logic [4:0] flags;

  logic [N_BYTES-1:0] tlp_be_d, tlp_end_d, tlp_nullify_d;
  logic [N_BYTES-1:0] dllp_be_d, dllp_end_d, frame_err_d;

  // Lane chain: each lane sees the mode left behind by the lane below it.
  always_comb begin
    cur_mode      = mode_q;
    cur_cnt       = dcnt_q;
    flags         = '0;
    tlp_be_d      = '0;
    tlp_end_d     = '0;
    tlp_nullify_d = '0;
    dllp_be_d     = '0;
    dllp_end_d    = '0;
    frame_err_d   = '0;
    for (int unsigned i = 0; i < N_BYTES; i++) begin
      flags = {tlpstart[i], tlpend[i], tlpedb[i], dlpstart[i], dlpend[i]};
      if (valid_in[i]) begin
        if ((flags & (flags - 5'd1)) != 5'd0) begin
          frame_err_d[i] = 1'b1;
          cur_mode       = StIdle;
        end else begin
          case (cur_mode)
            StIdle: begin
              if (tlpstart[i]) begin
                cur_mode = StTlp;
              end else if (dlpstart[i]) begin
                cur_mode = StDllp;
                cur_cnt  = 3'd0;
              end else if (flags != 5'd0) begin
                frame_err_d[i] = 1'b1;
              end
            end
            StTlp: begin
              if (flags == 5'd0) begin
                tlp_be_d[i] = 1'b1;
              end else if (tlpend[i]) begin
                tlp_end_d[i] = 1'b1;
                cur_mode     = StIdle;
              end else if (tlpedb[i]) begin
                tlp_nullify_d[i] = 1'b1;
                cur_mode         = StIdle;
              end else if (tlpstart[i]) begin
                frame_err_d[i] = 1'b1;
              end else if (dlpstart[i]) begin
                frame_err_d[i] = 1'b1;
                cur_mode       = StDllp;
                cur_cnt        = 3'd0;
              end else begin
                frame_err_d[i] = 1'b1;
                cur_mode       = StIdle;
              end
            end
            StDllp: begin
              if (flags == 5'd0) begin
                dllp_be_d[i] = 1'b1;
                if (cur_cnt != 3'd7) cur_cnt = cur_cnt + 3'd1;
              end else if (dlpend[i]) begin
                if (cur_cnt == DllpLen) dllp_end_d[i] = 1'b1;
                else                    frame_err_d[i] = 1'b1;
                cur_mode = StIdle;
              end else if (tlpstart[i]) begin
                frame_err_d[i] = 1'b1;
                cur_mode       = StTlp;
              end else if (dlpstart[i]) begin
                frame_err_d[i] = 1'b1;
                cur_cnt        = 3'd0;
              end else begin
                frame_err_d[i] = 1'b1;
                cur_mode       = StIdle;
              end
            end
            default: cur_mode = StIdle;
          endcase
        end
      end
    end
    mode_d = cur_mode;
    dcnt_d = cur_cnt;
  end

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [N_BYTES-1:0] m);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'($countones(m));
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q      <= StIdle;
      dcnt_q      <= 3'd0;
      data_out    <= '0;
      tlp_be      <= '0;
      tlp_end     <= '0;
      tlp_nullify <= '0;
      dllp_be     <= '0;
      dllp_end    <= '0;
      frame_err   <= '0;
      err_pulse   <= 1'b0;
      tlp_cnt     <= '0;
      dllp_cnt    <= '0;
      err_cnt     <= '0;
    end else begin
      mode_q      <= mode_d;
      dcnt_q      <= dcnt_d;
      data_out    <= data_in;
      tlp_be      <= tlp_be_d;
      tlp_end     <= tlp_end_d;
      tlp_nullify <= tlp_nullify_d;
      dllp_be     <= dllp_be_d;
      dllp_end    <= dllp_end_d;
      frame_err   <= frame_err_d;
      err_pulse   <= |frame_err_d;
      // Counters advance on the same edge that registers the masks they count.
      if (clr_cnt) begin
        tlp_cnt  <= '0;
        dllp_cnt <= '0;
        err_cnt  <= '0;
      end else begin
        tlp_cnt  <= sat_add(tlp_cnt, tlp_end_d);
        dllp_cnt <= sat_add(dllp_cnt, dllp_end_d);
        err_cnt  <= sat_add(err_cnt, frame_err_d);
      end
    end
  end

endmodule

// File: tb/tb_gen1_2_rx_packet_filter.sv
// Bench for gen1_2_rx_packet_filter: directed framing scenarios, random beats, counter
// saturation and mid-packet reset, all checked against a byte-level framing model.
module tb_gen1_2_rx_packet_filter;

  localparam int NB = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic [8*NB-1:0] data_in;
  logic [NB-1:0] valid_in, tlpstart, tlpend, tlpedb, dlpstart, dlpend;
  logic          clr_cnt;
  logic [8*NB-1:0] data_out;
  logic [NB-1:0] tlp_be, tlp_end, tlp_nullify, dllp_be, dllp_end, frame_err;
  logic          err_pulse;
  logic [15:0]   tlp_cnt, dllp_cnt, err_cnt;

  gen1_2_rx_packet_filter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .tlpstart   (tlpstart),
    .tlpend     (tlpend),
    .tlpedb     (tlpedb),
    .dlpstart   (dlpstart),
    .dlpend     (dlpend),
    .clr_cnt    (clr_cnt),
    .data_out   (data_out),
    .tlp_be     (tlp_be),
    .tlp_end    (tlp_end),
    .tlp_nullify(tlp_nullify),
    .dllp_be    (dllp_be),
    .dllp_end   (dllp_end),
    .frame_err  (frame_err),
    .err_pulse  (err_pulse),
    .tlp_cnt    (tlp_cnt),
    .dllp_cnt   (dllp_cnt),
    .err_cnt    (err_cnt)
  );

  int tests = 0;
  int fails = 0;

  // Model: 0 = outside a packet, 1 = inside a TLP, 2 = inside a DLLP.
  int              m_mode;
  int              m_body;
  logic [8*NB-1:0] e_data;
  logic [NB-1:0]   e_tbe, e_tend, e_tnul, e_dbe, e_dend, e_ferr;
  logic            e_pulse;
  logic [15:0]     e_tcnt, e_dcnt, e_ecnt;

  function automatic logic [15:0] sat16(input logic [15:0] a, input int n);
    int s;
    s = int'(a) + n;
    return (s > 65535) ? 16'hFFFF : 16'(s);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_body = 0;
    e_data = '0; e_tbe = '0; e_tend = '0; e_tnul = '0; e_dbe = '0; e_dend = '0; e_ferr = '0;
    e_pulse = 1'b0; e_tcnt = '0; e_dcnt = '0; e_ecnt = '0;
  endtask

  task automatic model_beat();
    logic [NB-1:0] tbe, tend, tnul, dbe, dend, ferr;
    tbe = '0; tend = '0; tnul = '0; dbe = '0; dend = '0; ferr = '0;
    for (int i = 0; i < NB; i++) begin
      int nf;
      if (!valid_in[i]) continue;
      nf = int'(tlpstart[i]) + int'(tlpend[i]) + int'(tlpedb[i]) + int'(dlpstart[i])
         + int'(dlpend[i]);
      if (nf > 1) begin
        ferr[i] = 1'b1; m_mode = 0;
      end else if (nf == 0) begin
        if (m_mode == 1) tbe[i] = 1'b1;
        else if (m_mode == 2) begin dbe[i] = 1'b1; m_body++; end
      end else if (tlpstart[i] || dlpstart[i]) begin
        if (m_mode != 0) ferr[i] = 1'b1;
        m_mode = tlpstart[i] ? 1 : 2;
        m_body = 0;
      end else if (tlpend[i] && m_mode == 1) begin
        tend[i] = 1'b1; m_mode = 0;
      end else if (tlpedb[i] && m_mode == 1) begin
        tnul[i] = 1'b1; m_mode = 0;
      end else if (dlpend[i] && m_mode == 2 && m_body == 6) begin
        dend[i] = 1'b1; m_mode = 0;
      end else begin
        ferr[i] = 1'b1; m_mode = 0;
      end
    end
    e_data = data_in; e_tbe = tbe; e_tend = tend; e_tnul = tnul;
    e_dbe = dbe; e_dend = dend; e_ferr = ferr; e_pulse = |ferr;
    if (clr_cnt) begin
      e_tcnt = '0; e_dcnt = '0; e_ecnt = '0;
    end else begin
      e_tcnt = sat16(e_tcnt, $countones(tend));
      e_dcnt = sat16(e_dcnt, $countones(dend));
      e_ecnt = sat16(e_ecnt, $countones(ferr));
    end
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("data_out",    512'(data_out),    512'(e_data));
    chk("tlp_be",      512'(tlp_be),      512'(e_tbe));
    chk("tlp_end",     512'(tlp_end),     512'(e_tend));
    chk("tlp_nullify", 512'(tlp_nullify), 512'(e_tnul));
    chk("dllp_be",     512'(dllp_be),     512'(e_dbe));
    chk("dllp_end",    512'(dllp_end),    512'(e_dend));
    chk("frame_err",   512'(frame_err),   512'(e_ferr));
    chk("err_pulse",   512'(err_pulse),   512'(e_pulse));
    chk("tlp_cnt",     512'(tlp_cnt),     512'(e_tcnt));
    chk("dllp_cnt",    512'(dllp_cnt),    512'(e_dcnt));
    chk("err_cnt",     512'(err_cnt),     512'(e_ecnt));
  endtask

  task automatic new_beat();
    for (int w = 0; w < 8*NB/32; w++) data_in[32*w +: 32] = $urandom;
    valid_in = '1; tlpstart = '0; tlpend = '0; tlpedb = '0; dlpstart = '0; dlpend = '0;
    clr_cnt = 1'b0;
  endtask

  // k: 0 STP, 1 END(TLP), 2 EDB, 3 SDP, 4 END(DLLP)
  task automatic set_flag(input int i, input int k);
    case (k)
      0: tlpstart[i] = 1'b1;
      1: tlpend[i]   = 1'b1;
      2: tlpedb[i]   = 1'b1;
      3: dlpstart[i] = 1'b1;
      default: dlpend[i] = 1'b1;
    endcase
  endtask

  // k: 0 body, 1..5 flag (k-1), 6 hole
  task automatic lane(input int i, input int k);
    if (k == 6) valid_in[i] = 1'b0;
    else if (k > 0) set_flag(i, k - 1);
  endtask

  task automatic random_beat();
    new_beat();
    for (int i = 0; i < NB; i++) begin
      int r, a;
      r = $urandom_range(0, 15);
      if (r >= 8 && r <= 12) set_flag(i, r - 8);
      else if (r == 13) begin
        a = $urandom_range(0, 4);
        set_flag(i, a);
        set_flag(i, (a + 1 + $urandom_range(0, 3)) % 5);
      end else if (r >= 14) begin
        valid_in[i] = 1'b0;
        set_flag(i, $urandom_range(0, 4));
      end
    end
    clr_cnt = ($urandom_range(0, 19) == 0);
  endtask

  task automatic step();
    model_beat();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    reset_n = 1'b0;
    new_beat();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset_n = 1'b1;

    // Single TLP inside one beat.
    new_beat(); lane(0, 1); lane(21, 2);
    step();
    chk("t1_tlp_be", 512'(tlp_be), 512'(64'h1F_FFFE));
    chk("t1_tlp_end", 512'(tlp_end), 512'(64'h20_0000));
    chk("t1_tlp_cnt", 512'(tlp_cnt), 512'(1));

    // DLLP spanning two beats.
    new_beat(); lane(60, 4);
    step();
    chk("t2_dllp_be0", 512'(dllp_be), 512'(64'hE000_0000_0000_0000));
    new_beat(); lane(3, 5);
    step();
    chk("t2_dllp_be1", 512'(dllp_be), 512'(64'h7));
    chk("t2_dllp_end", 512'(dllp_end), 512'(64'h8));
    chk("t2_dllp_cnt", 512'(dllp_cnt), 512'(1));

    // Short DLLP.
    new_beat(); lane(0, 4); lane(6, 5);
    step();
    chk("t3_frame_err", 512'(frame_err), 512'(64'h40));
    chk("t3_err_cnt", 512'(err_cnt), 512'(1));

    // Nullified TLP.
    new_beat(); lane(0, 1); lane(11, 3);
    step();
    chk("t4_nullify", 512'(tlp_nullify), 512'(64'h800));
    chk("t4_tlp_cnt", 512'(tlp_cnt), 512'(1));

    // Two TLPs in one beat with holes.
    new_beat(); lane(0, 1); lane(3, 6); lane(5, 2); lane(6, 1); lane(7, 6); lane(9, 6);
    lane(10, 2);
    step();
    chk("t5_tlp_end", 512'(tlp_end), 512'(64'h420));
    chk("t5_tlp_be", 512'(tlp_be), 512'(64'h116));
    chk("t5_tlp_cnt", 512'(tlp_cnt), 512'(3));

    for (int n = 0; n < 300; n++) begin
      random_beat();
      step();
    end

    // Drive tlp_cnt to saturation with 32 empty TLPs per beat.
    new_beat(); clr_cnt = 1'b1;
    step();
    for (int n = 0; n < 2047; n++) begin
      new_beat();
      for (int i = 0; i < 32; i++) begin lane(2*i, 1); lane(2*i + 1, 2); end
      step();
    end
    chk("sat_pre", 512'(tlp_cnt), 512'(65504));
    new_beat();
    for (int i = 0; i < 31; i++) begin lane(2*i, 1); lane(2*i + 1, 2); end
    step();
    chk("sat_full", 512'(tlp_cnt), 512'(16'hFFFF));
    new_beat();
    for (int i = 0; i < 3; i++) begin lane(2*i, 1); lane(2*i + 1, 2); end
    step();
    chk("sat_hold", 512'(tlp_cnt), 512'(16'hFFFF));
    new_beat(); lane(0, 1); lane(1, 2); clr_cnt = 1'b1;
    step();
    chk("clr_prio", 512'(tlp_cnt), 512'(0));

    // Reset in the middle of a TLP.
    new_beat(); lane(0, 1);
    step();
    new_beat();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step();
    chk("rst_body_ignored", 512'(tlp_be), 512'(0));
    new_beat(); lane(0, 1); lane(5, 2);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
